// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one block memory between the icache and dcache ports.
// Transfers are serialised, and simultaneous misses alternate between the ports.
module mem_port_arbiter #(
  parameter int ADDR_W  = 6,
  parameter int BLOCK_W = 128
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_read,
  input  logic [ADDR_W-1:0]  i_address,
  output logic [BLOCK_W-1:0] i_readdata,
  output logic               i_busywait,
  input  logic               d_read,
  input  logic               d_write,
  input  logic [ADDR_W-1:0]  d_address,
  input  logic [BLOCK_W-1:0] d_writedata,
  output logic [BLOCK_W-1:0] d_readdata,
  output logic               d_busywait,
  output logic               mem_read,
  output logic               mem_write,
  output logic [ADDR_W:0]    mem_address,
  output logic [BLOCK_W-1:0] mem_writedata,
  input  logic [BLOCK_W-1:0] mem_readdata,
  input  logic               mem_busywait
);
  typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} state_t;

  state_t             state_q, state_d;
  logic               owner_q, owner_d;
  logic               last_q, last_d;
  logic               first_q, first_d;
  logic               i_done_q, i_done_d;
  logic               d_done_q, d_done_d;
  logic               mem_read_q, mem_read_d;
  logic               mem_write_q, mem_write_d;
  logic [ADDR_W:0]    mem_address_q, mem_address_d;
  logic [BLOCK_W-1:0] mem_writedata_q, mem_writedata_d;
  logic [BLOCK_W-1:0] i_readdata_q, i_readdata_d;
  logic [BLOCK_W-1:0] d_readdata_q, d_readdata_d;
  logic               i_req, d_req, gnt;

  // Owner, last_grant and the grant choice all encode 0 = icache, 1 = dcache.
  assign i_req = i_read;
  assign d_req = d_read | d_write;
  assign gnt   = (i_req & d_req) ? ~last_q : d_req;

  assign i_busywait    = reset & i_req & ~i_done_q;
  assign d_busywait    = reset & d_req & ~d_done_q;
  assign i_readdata    = i_readdata_q;
  assign d_readdata    = d_readdata_q;
  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign mem_address   = mem_address_q;
  assign mem_writedata = mem_writedata_q;

  // Both dcache strobes at once is illegal; the write takes precedence.
  assert property (@(posedge clock) disable iff (!reset) !(d_read && d_write))
    else $warning("mem_port_arbiter: d_read and d_write both high, write wins");

  // Transfer FSM: grant from IDLE, hold the strobes through ACCESS, then one RELEASE cycle.
  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    last_d          = last_q;
    first_d         = first_q;
    i_done_d        = i_done_q;
    d_done_d        = d_done_q;
    mem_read_d      = mem_read_q;
    mem_write_d     = mem_write_q;
    mem_address_d   = mem_address_q;
    mem_writedata_d = mem_writedata_q;
    i_readdata_d    = i_readdata_q;
    d_readdata_d    = d_readdata_q;
    case (state_q)
      IDLE: if (i_req | d_req) begin
        owner_d         = gnt;
        mem_address_d   = {gnt, gnt ? d_address : i_address};
        mem_write_d     = gnt & d_write;
        mem_read_d      = ~(gnt & d_write);
        mem_writedata_d = (gnt & d_write) ? d_writedata : mem_writedata_q;
        first_d         = 1'b1;
        state_d         = ACCESS;
      end
      ACCESS: if (first_q) begin
        first_d = 1'b0;
      end else if (!mem_busywait) begin
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        i_readdata_d = (mem_read_q & ~owner_q) ? mem_readdata : i_readdata_q;
        d_readdata_d = (mem_read_q & owner_q) ? mem_readdata : d_readdata_q;
        i_done_d     = ~owner_q;
        d_done_d     = owner_q;
        last_d       = owner_q;
        state_d      = RELEASE;
      end
      RELEASE: begin
        i_done_d = 1'b0;
        d_done_d = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; the icache wins the first tie after reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      owner_q         <= 1'b0;
      last_q          <= 1'b1;
      first_q         <= 1'b0;
      i_done_q        <= 1'b0;
      d_done_q        <= 1'b0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_address_q   <= '0;
      mem_writedata_q <= '0;
      i_readdata_q    <= '0;
      d_readdata_q    <= '0;
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      last_q          <= last_d;
      first_q         <= first_d;
      i_done_q        <= i_done_d;
      d_done_q        <= d_done_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      mem_address_q   <= mem_address_d;
      mem_writedata_q <= mem_writedata_d;
      i_readdata_q    <= i_readdata_d;
      d_readdata_q    <= d_readdata_d;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random transfers against a transaction-level model.
`define CHK(tag, obs, exp) begin nasrt++; assert ((obs) === (exp)) else begin nfail++; $error("FAIL %s: observed %0h expected %0h", tag, obs, exp); end end

module tb_mem_port_arbiter;
  logic         clock, reset;
  logic         i_read, d_read, d_write;
  logic [5:0]   i_address, d_address;
  logic [127:0] i_readdata, d_readdata, d_writedata;
  logic         i_busywait, d_busywait;
  logic         mem_read, mem_write, mem_busywait;
  logic [6:0]   mem_address;
  logic [127:0] mem_writedata, mem_readdata;

  int           nasrt = 0, nfail = 0;
  int           lat = 0, cnt = 0;
  logic         seen = 1'b0;
  logic [127:0] mem [128];
  logic [127:0] mem_ref [128];
  logic [127:0] exp_ird, exp_drd;
  logic         last_g;

  localparam logic [127:0] A5 = 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A501;
  localparam logic [127:0] WD = 128'h12345678_9ABCDEF0_0FEDCBA9_87654321;

  mem_port_arbiter #(.ADDR_W(6), .BLOCK_W(128)) dut (
    .clock(clock), .reset(reset),
    .i_read(i_read), .i_address(i_address), .i_readdata(i_readdata), .i_busywait(i_busywait),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_writedata(d_writedata),
    .d_readdata(d_readdata), .d_busywait(d_busywait),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory environment: busy for 'lat' cycles starting one edge after it first sees a strobe.
  assign mem_readdata = mem[mem_address];
  assign mem_busywait = seen && cnt != 0;
  always @(posedge clock) begin
    if (!(mem_read || mem_write)) begin
      seen <= 1'b0;
      cnt  <= 0;
    end else if (!seen) begin
      seen <= 1'b1;
      cnt  <= lat;
    end else if (cnt != 0) cnt <= cnt - 1;
    if (mem_write) mem[mem_address] <= mem_writedata;
  end

  task automatic do_reset();
    reset = 1'b1;
    #1 reset = 1'b0;
    i_read = 1'b1; d_read = 1'b1; d_write = 1'b0;
    i_address = '0; d_address = '0; d_writedata = '0;
    #1;
    `CHK("rst_i_bw", i_busywait, 1'b0)
    `CHK("rst_d_bw", d_busywait, 1'b0)
    i_read = 1'b0; d_read = 1'b0;
    @(posedge clock);
    #1;
    `CHK("rst_outs", {mem_read, mem_write, mem_address, mem_writedata, i_readdata, d_readdata}, '0)
    #1 reset = 1'b1;
    last_g = 1'b1; exp_ird = '0; exp_drd = '0;
  endtask

  // One transaction: optional icache read and optional dcache read or write issued together.
  task automatic run_pair(input logic ir, input logic dr, input logic dw, input logic [5:0] ia,
                          input logic [5:0] da, input logic [127:0] wd, input int l);
    logic [6:0]   ea [2];
    logic         er [2], ew [2];
    logic         dfirst, ip, dp, prev, s;
    logic [127:0] ei, ed;
    int           n, cyc, xi, scnt, bad, ti, td;
    lat = l;
    ip = ir; dp = dr | dw; n = 0;
    dfirst = dp && (!ip || last_g == 1'b0);
    if (dfirst) begin ea[n] = {1'b1, da}; er[n] = ~dw; ew[n] = dw; n++; end
    if (ip) begin ea[n] = {1'b0, ia}; er[n] = 1'b1; ew[n] = 1'b0; n++; end
    if (dp && !dfirst) begin ea[n] = {1'b1, da}; er[n] = ~dw; ew[n] = dw; n++; end
    ti = (ip && dfirst) ? 7 + 2 * l : 3 + l;
    td = (dp && !dfirst && ip) ? 7 + 2 * l : 3 + l;
    ei = mem_ref[{1'b0, ia}];
    ed = dw ? exp_drd : mem_ref[{1'b1, da}];
    i_address = ia; d_address = da; d_writedata = wd;
    i_read = ir; d_read = dr; d_write = dw;
    cyc = 0; xi = 0; scnt = 0; bad = 0; prev = 1'b0;
    while ((ip || dp) && cyc < 200) begin
      @(posedge clock);
      #1;
      cyc++;
      s = mem_read | mem_write;
      scnt += int'(s);
      if (s && !prev && xi < n) begin
        `CHK("xfer_addr", mem_address, ea[xi])
        `CHK("xfer_rd", mem_read, er[xi])
        `CHK("xfer_wr", mem_write, ew[xi])
        if (ew[xi]) `CHK("xfer_wdata", mem_writedata, wd)
        xi++;
      end
      prev = s;
      if (!ip && i_busywait) bad++;
      if (!dp && d_busywait) bad++;
      if (ip && !i_busywait) begin
        `CHK("i_latency", cyc, ti)
        `CHK("i_data", i_readdata, ei)
        ip = 1'b0; i_read = 1'b0;
      end
      if (dp && !d_busywait) begin
        `CHK("d_latency", cyc, td)
        if (!dw) `CHK("d_data", d_readdata, ed)
        dp = 1'b0; d_read = 1'b0; d_write = 1'b0;
      end
    end
    `CHK("timeout", ip | dp, 1'b0)
    `CHK("strobe_cycles", scnt, n * (2 + l))
    `CHK("xfer_count", xi, n)
    `CHK("idle_port_bw", bad, 0)
    if (ir) exp_ird = ei;
    if (dr) exp_drd = ed;
    if (dw) mem_ref[{1'b1, da}] = wd;
    if (n == 2) last_g = ~dfirst;
    else if (n == 1) last_g = dfirst;
    @(posedge clock);
    #1;
    `CHK("post_strobes", mem_read | mem_write, 1'b0)
    `CHK("post_i_rdata", i_readdata, exp_ird)
    `CHK("post_d_rdata", d_readdata, exp_drd)
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int strobes;
    logic [5:0] da;
    for (int k = 0; k < 128; k++) begin
      mem[k] = {$urandom, $urandom, $urandom, $urandom};
      mem_ref[k] = mem[k];
    end
    mem[7'h15] = A5; mem_ref[7'h15] = A5;
    do_reset();
    lat = 4; strobes = 0;
    repeat (5) begin
      @(posedge clock);
      #1;
      strobes += int'(mem_read | mem_write | i_busywait | d_busywait);
    end
    `CHK("idle_quiet", strobes, 0)
    i_address = 6'h15; i_read = 1'b1;
    @(posedge clock);
    #1;
    `CHK("t2_addr", mem_address, 7'h15)
    `CHK("t2_rd", mem_read, 1'b1)
    cyc = 1; strobes = 0;
    while (i_busywait && cyc < 100) begin
      @(posedge clock);
      #1;
      cyc++;
      strobes += int'(d_busywait);
    end
    `CHK("t2_latency", cyc, 7)
    `CHK("t2_data", i_readdata, A5)
    `CHK("t2_d_bw", strobes, 0)
    @(posedge clock);
    #1;
    `CHK("t2_bw_back", i_busywait, 1'b1)
    i_read = 1'b0;
    @(posedge clock);
    #1;
    `CHK("t2_no_regrant", mem_read, 1'b0)
    @(posedge clock);
    #1;
    `CHK("t2_idle", {mem_read, i_busywait}, 2'b00)
    do_reset();
    run_pair(1'b1, 1'b0, 1'b1, 6'h03, 6'h03, WD, 2);
    `CHK("t3_written", mem[7'h43], WD)
    for (int k = 0; k < 3; k++)
      run_pair(1'b1, 1'b1, 1'b0, 6'(k + 8), 6'(k + 20), '0, 0);
    da = 6'h2A; d_address = da; d_read = 1'b1; lat = 4;
    @(posedge clock);
    #1;
    `CHK("t5_grant", mem_read, 1'b1)
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    `CHK("t5_rd_drop", mem_read, 1'b0)
    `CHK("t5_d_rdata", d_readdata, 128'h0)
    `CHK("t5_d_bw", d_busywait, 1'b0)
    last_g = 1'b1; exp_ird = '0; exp_drd = '0;
    @(posedge clock);
    #2 reset = 1'b1;
    run_pair(1'b0, 1'b1, 1'b0, 6'h00, da, '0, 4);
    for (int k = 0; k < 30; k++) begin
      int dsel;
      dsel = int'($urandom_range(0, 2));
      run_pair(1'($urandom_range(0, 1)), dsel == 1, dsel == 2, 6'($urandom), 6'($urandom),
               {$urandom, $urandom, $urandom, $urandom}, int'($urandom_range(0, 3)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nasrt, nfail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 128-bit-block main memory between the instruction cache (read-only) and the data cache (read/write).
- Sits between both cache controllers' main-memory ports and the one memory instance.
- Serialises block transfers, fairly arbitrates simultaneous misses, and returns each requester's data and busywait as if it owned the memory.
- The address space is unified: the MSB of the memory address selects the instruction region (0) or the data region (1).

Parameters:
- ADDR_W, 6, block-address width of each cache port; the memory address is ADDR_W+1 bits.
- BLOCK_W, 128, block width in bits.

Ports:
- clock  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- i_read  in  1  icache block-read request; level, held until i_busywait low.
- i_address  in  ADDR_W  icache block address.
- i_readdata  out  BLOCK_W  block returned to icache; registered.
- i_busywait  out  1  icache stall.
- d_read  in  1  dcache block-read request; level.
- d_write  in  1  dcache block-write (write-back) request; level.
- d_address  in  ADDR_W  dcache block address.
- d_writedata  in  BLOCK_W  dcache write block.
- d_readdata  out  BLOCK_W  block returned to dcache; registered.
- d_busywait  out  1  dcache stall.
- mem_read  out  1  memory read strobe; registered.
- mem_write  out  1  memory write strobe; registered.
- mem_address  out  ADDR_W+1  {region, block address}; registered.
- mem_writedata  out  BLOCK_W  registered.
- mem_readdata  in  BLOCK_W  memory read block.
- mem_busywait  in  1  memory busy.

Behaviour:
- Reset (reset=0, async): state=IDLE, last_grant=D (so the icache wins the first tie).
  - All registered outputs go to 0.
  - i_busywait and d_busywait are forced to 0 while reset is low.
  - A reset mid-access drops the memory strobes immediately; the transfer is abandoned and no done is signalled.
- Requests: i_req=i_read; d_req=d_read|d_write.
  - If d_read and d_write are both high, this is illegal: the write wins and a simulation warning is flagged.
- Busywait is combinational: x_busywait = x_req & ~x_done.
  - x_done is a registered flag, high only during RELEASE for the owning port.
- FSM states: IDLE, ACCESS, RELEASE.
- IDLE:
  - No request: stay.
  - Exactly one request: grant it.
  - Both requesting: grant the port not equal to last_grant.
  - On the grant posedge:
    - owner <= granted port.
    - mem_address <= {0,i_address} for I or {1,d_address} for D.
    - mem_read <= 1 for I or a D read; mem_write <= 1 for a D write.
    - mem_writedata <= d_writedata for a D write, otherwise unchanged.
    - first <= 1; go to ACCESS.
- ACCESS:
  - Strobes, address and writedata are held stable.
  - The first posedge in ACCESS clears first, and mem_busywait is ignored at that edge. This covers memory that raises busywait after the strobe.
  - At any later posedge with mem_busywait=0:
    - Clear the strobes.
    - For a read, capture mem_readdata into the owner's readdata register; the other port's readdata is unchanged.
    - Set the owner's x_done; last_grant <= owner; go to RELEASE.
- RELEASE: exactly one cycle.
  - Strobes are 0 and the owner's busywait is 0.
  - At the next posedge, clear x_done and go to IDLE.
  - Another pending request is re-arbitrated from IDLE, so back-to-back grants are separated by at least one IDLE cycle.
- Minimum latency from request to busywait low: 1 IDLE + 2 ACCESS + RELEASE (busywait drops at the start of RELEASE), i.e. 3 posedges after the request is sampled with zero-wait memory. It grows 1:1 with memory busy cycles.
- Non-owner port: its busywait stays high for the entire foreign transfer. No preemption occurs.
- Request withdrawn mid-ACCESS: the memory transfer still completes, because the memory cannot abort. The data is captured, RELEASE occurs, and busywait is 0 since there is no request.
- Request withdrawn while waiting in IDLE: it is ignored, and last_grant is unaffected.
- A requester changing its address during its own ACCESS is not propagated; the latched address is used.
- Starvation bound: a waiting port is granted within one foreign transfer.

Test Plan:
- Reset release, no requests (memory model with 4-cycle busywait) -> all outputs 0, state stays IDLE, mem strobes never assert.
- icache-only request, i_read=1, i_address=6'h15, memory returns 128'hA5A5...01 -> mem_address=7'h15, mem_read=1, i_readdata=128'hA5A5...01, i_busywait low for exactly 1 cycle; d_busywait=0 throughout.
- Simultaneous i_read (addr 6'h03) and d_write (addr 6'h03, data 128'h1234...) after reset:
  - I is served first (mem_address=7'h03), then D (mem_address=7'h43, mem_write=1, mem_writedata=128'h1234...).
  - d_busywait is held high through the whole I transfer.
- Alternating fairness: both ports request continuously for 6 transfers -> grant order I,D,I,D,I,D; no port is served twice consecutively while the other waits.
- Reset (reset=0) asserted during D-read ACCESS with memory busy -> mem_read drops without waiting for a clock, d_readdata=0, and after release the pending d_read is re-granted from IDLE.
- Zero-wait memory (mem_busywait always 0) -> mem_read is high for exactly 2 cycles per transfer, and data is captured at the second ACCESS posedge, not the first.
